// File: rtl/slave_link_uart_if.sv
// Signal bundle for the slave link endpoint: board-to-board wires plus the game-side
// attack/board handshake. The slave modport is the endpoint's view.
interface slave_link_uart_if #(
  parameter int WIDTH = 16
);
  logic             mas_bs_in;
  logic             mas_sig_in;
  logic [WIDTH-1:0] board;
  logic             send_req;
  logic [WIDTH-1:0] attack_data;
  logic             attack_valid;
  logic             frame_err;
  logic             slav_bs_out;
  logic             slav_sig_out;
  logic             tx_busy;

  modport slave (
    input  mas_bs_in, mas_sig_in, board, send_req,
    output attack_data, attack_valid, frame_err, slav_bs_out, slav_sig_out, tx_busy
  );

  modport master (
    output mas_bs_in, mas_sig_in, board, send_req,
    input  attack_data, attack_valid, frame_err, slav_bs_out, slav_sig_out, tx_busy
  );
endinterface

// File: rtl/slave_link_uart.sv
// Slave endpoint of the master/slave serial link: RX deserializer for attack words and
// TX serializer for the board word with a one-deep request latch and optional auto-reply.
module slave_link_uart #(
  parameter int WIDTH        = 16,
  parameter int CLKS_PER_BIT = 100,
  parameter int GAP_CYCLES   = 4,
  parameter int AUTO_REPLY   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  slave_link_uart_if.slave link
);

  localparam int BIT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CNT_MAX = (CLKS_PER_BIT > GAP_CYCLES) ? CLKS_PER_BIT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] CPB_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WIDTH - 1);

  // Two-flop synchronizers; index 1 is the frame signal, index 0 the bitstream.
  logic [1:0] raw_in;
  logic [1:0] sync_s;
  assign raw_in = {link.mas_sig_in, link.mas_bs_in};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    logic meta_reg;
    logic sync_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        meta_reg <= 1'b0;
        sync_reg <= 1'b0;
      end else begin
        meta_reg <= raw_in[gi];
        sync_reg <= meta_reg;
      end
    end
    assign sync_s[gi] = sync_reg;
  end

  logic sig_s, bs_s;
  assign sig_s = sync_s[1];
  assign bs_s  = sync_s[0];

  typedef enum logic [1:0] {R_IDLE, R_DATA, R_DONE, R_WAIT} rx_state_t;
  rx_state_t        rx_state_reg;
  logic [CNT_W-1:0] rx_cnt_reg;
  logic [BIT_W-1:0] rx_bit_reg;
  logic [WIDTH-1:0] rx_shift_reg;
  logic [WIDTH-1:0] attack_data_reg;
  logic             attack_valid_reg;
  logic             frame_err_reg;
  logic             sig_prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_reg     <= R_IDLE;
      rx_cnt_reg       <= '0;
      rx_bit_reg       <= '0;
      rx_shift_reg     <= '0;
      attack_data_reg  <= '0;
      attack_valid_reg <= 1'b0;
      frame_err_reg    <= 1'b0;
      sig_prev_reg     <= 1'b0;
    end else begin
      attack_valid_reg <= 1'b0;
      frame_err_reg    <= 1'b0;
      sig_prev_reg     <= sig_s;
      case (rx_state_reg)
        R_IDLE: begin
          if (sig_s && !sig_prev_reg) begin
            rx_state_reg <= R_DATA;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
          end
        end
        R_DATA: begin
          if (!sig_s) begin
            frame_err_reg <= 1'b1;
            rx_shift_reg  <= '0;
            rx_state_reg  <= R_IDLE;
          end else begin
            // Sample mid-bit; the last sample completes the word.
            if (rx_cnt_reg == SAMPLE_AT) begin
              rx_shift_reg[rx_bit_reg] <= bs_s;
              if (rx_bit_reg == BIT_LAST) rx_state_reg <= R_DONE;
            end
            if (rx_cnt_reg == CPB_LAST) begin
              rx_cnt_reg <= '0;
              rx_bit_reg <= rx_bit_reg + 1'b1;
            end else begin
              rx_cnt_reg <= rx_cnt_reg + 1'b1;
            end
          end
        end
        R_DONE: begin
          attack_data_reg  <= rx_shift_reg;
          attack_valid_reg <= 1'b1;
          rx_state_reg     <= R_WAIT;
        end
        R_WAIT: begin
          if (!sig_s) rx_state_reg <= R_IDLE;
        end
        default: rx_state_reg <= R_IDLE;
      endcase
    end
  end

  typedef enum logic [1:0] {T_IDLE, T_DATA, T_GAP} tx_state_t;
  tx_state_t        tx_state_reg;
  logic [CNT_W-1:0] tx_cnt_reg;
  logic [BIT_W-1:0] tx_bit_reg;
  logic [WIDTH-1:0] tx_shift_reg;
  logic             tx_sig_reg;
  logic             pending_reg;
  logic             auto_req;
  logic             tx_req;

  assign auto_req = (AUTO_REPLY != 0) ? attack_valid_reg : 1'b0;
  assign tx_req   = link.send_req | auto_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_reg <= T_IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      tx_sig_reg   <= 1'b0;
      pending_reg  <= 1'b0;
    end else begin
      pending_reg <= pending_reg | tx_req;
      case (tx_state_reg)
        T_IDLE: begin
          // A request landing on the start cycle is kept for the following frame.
          if (pending_reg) begin
            tx_shift_reg <= link.board;
            tx_sig_reg   <= 1'b1;
            pending_reg  <= tx_req;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_state_reg <= T_DATA;
          end
        end
        T_DATA: begin
          if (tx_cnt_reg == CPB_LAST) begin
            tx_cnt_reg <= '0;
            if (tx_bit_reg == BIT_LAST) begin
              tx_sig_reg   <= 1'b0;
              tx_shift_reg <= '0;
              tx_state_reg <= T_GAP;
            end else begin
              tx_bit_reg   <= tx_bit_reg + 1'b1;
              tx_shift_reg <= tx_shift_reg >> 1;
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg + 1'b1;
          end
        end
        T_GAP: begin
          if (tx_cnt_reg == GAP_LAST) begin
            tx_cnt_reg   <= '0;
            tx_state_reg <= T_IDLE;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + 1'b1;
          end
        end
        default: tx_state_reg <= T_IDLE;
      endcase
    end
  end

  assign link.attack_data  = attack_data_reg;
  assign link.attack_valid = attack_valid_reg;
  assign link.frame_err    = frame_err_reg;
  assign link.slav_bs_out  = tx_shift_reg[0];
  assign link.slav_sig_out = tx_sig_reg;
  assign link.tx_busy      = pending_reg | (tx_state_reg != T_IDLE);

endmodule

// File: tb/tb_slave_link_uart.sv
// Bench for slave_link_uart: directed scenarios plus randomized frames, checked each cycle
// against a timeline model of the link built from frame start times and request arrivals.
module tb_slave_link_uart;
  localparam int W     = 16;
  localparam int CPB   = 100;
  localparam int GAP   = 4;
  localparam int AUTO  = 1;
  localparam int LAT   = 1553;  // 2 + 15*100 + 50 + 1
  localparam int FRAME = 1600;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  slave_link_uart_if #(.WIDTH(W)) link();

  slave_link_uart #(
    .WIDTH(W), .CLKS_PER_BIT(CPB), .GAP_CYCLES(GAP), .AUTO_REPLY(AUTO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .link(link)
  );

  typedef struct {
    int         t;
    logic [W-1:0] w;
  } rx_ev_t;

  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference timeline: expected RX events and the TX frame schedule.
  rx_ev_t       rxq[$];
  int           errq[$];
  logic [W-1:0] m_attack = '0;
  int           m_s = -100000;
  logic [W-1:0] m_sw = '0;
  bit           m_pend = 1'b0;
  int           m_next_ok = 0;
  int           valid_cnt = 0, err_cnt = 0, tx_rise_cnt = 0, last_valid_n = 0;
  logic         prev_sig = 1'b0;
  bit           in_frame, in_busy, req;
  int           last_n0 = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_attack = '0; m_s = -100000; m_pend = 1'b0; m_next_ok = 0;
      rxq.delete(); errq.delete(); prev_sig = 1'b0;
    end else begin
      if (link.attack_valid) begin
        valid_cnt++; last_valid_n = cyc_n;
        if (rxq.size() > 0 && cyc_n >= rxq[0].t - 1 && cyc_n <= rxq[0].t + 1) begin
          chk("attack_word", link.attack_data, rxq[0].w);
          m_attack = rxq[0].w;
          void'(rxq.pop_front());
        end else begin
          total++; bad++;
          $display("FAIL attack_valid_unexpected: got pulse at cycle %0d want none", cyc_n);
        end
      end
      if (rxq.size() > 0 && cyc_n > rxq[0].t + 1) begin
        total++; bad++;
        $display("FAIL attack_valid_missing: got none by cycle %0d want pulse near %0d", cyc_n, rxq[0].t);
        void'(rxq.pop_front());
      end
      chk("attack_data_hold", link.attack_data, m_attack);
      if (link.frame_err) begin
        err_cnt++;
        if (errq.size() > 0 && cyc_n >= errq[0] - 1 && cyc_n <= errq[0] + 1) begin
          total++;
          void'(errq.pop_front());
        end else begin
          total++; bad++;
          $display("FAIL frame_err_unexpected: got pulse at cycle %0d want none", cyc_n);
        end
      end
      if (errq.size() > 0 && cyc_n > errq[0] + 1) begin
        total++; bad++;
        $display("FAIL frame_err_missing: got none by cycle %0d want pulse near %0d", cyc_n, errq[0]);
        void'(errq.pop_front());
      end
      in_frame = (cyc_n >= m_s) && (cyc_n < m_s + W * CPB);
      in_busy  = (cyc_n >= m_s) && (cyc_n < m_s + W * CPB + GAP);
      chk("slav_sig_out", link.slav_sig_out, in_frame);
      chk("slav_bs_out", link.slav_bs_out, in_frame ? m_sw[(cyc_n - m_s) / CPB] : 1'b0);
      chk("tx_busy", link.tx_busy, m_pend || in_busy);
      if (link.slav_sig_out && !prev_sig) tx_rise_cnt++;
      prev_sig = link.slav_sig_out;
      // Requests seen now are latched at the next edge; a latched request starts a frame
      // at the first edge after the previous frame and its gap have elapsed.
      req = link.send_req || (AUTO != 0 && link.attack_valid);
      if (m_pend && cyc_n + 1 >= m_next_ok) begin
        m_s = cyc_n + 1;
        m_sw = link.board;
        m_next_ok = m_s + W * CPB + GAP + 1;
        m_pend = req;
      end else begin
        m_pend = m_pend || req;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_mas(input logic [W-1:0] word, input int nbits, input bit rnd_req,
                          input bit req_on_valid, input int idle);
    rx_ev_t ev;
    int     n0;
    n0 = cyc_n;
    last_n0 = n0;
    link.mas_sig_in = 1'b1;
    if (nbits == W) begin
      ev.t = n0 + LAT; ev.w = word; rxq.push_back(ev);
    end
    for (int c = 0; c < nbits * CPB; c++) begin
      link.mas_bs_in = word[c / CPB];
      link.send_req  = (rnd_req && $urandom_range(0, 599) == 0) || (req_on_valid && link.attack_valid);
      step();
    end
    link.mas_sig_in = 1'b0;
    link.mas_bs_in  = 1'b0;
    link.send_req   = 1'b0;
    if (nbits < W) errq.push_back(cyc_n + 3);
    $display("rx frame word=0x%h bits=%0d start=%0d", word, nbits, n0);
    for (int i = 0; i < idle; i++) begin
      link.send_req = rnd_req && ($urandom_range(0, 599) == 0);
      step();
    end
    link.send_req = 1'b0;
  endtask

  task automatic tx_observe(input logic [W-1:0] exp_w, input string tag);
    int k = 0, hi = 0, lo = 0;
    logic [W-1:0] w = '0;
    @(negedge clk);
    while (!link.slav_sig_out && k < 5000) begin @(negedge clk); k++; end
    if (k >= 5000) begin
      total++; bad++;
      $display("FAIL %s_start: got no frame want one", tag);
      return;
    end
    while (link.slav_sig_out && hi < W * CPB + 20) begin
      if (hi % CPB == CPB / 2 && hi / CPB < W) w[hi / CPB] = link.slav_bs_out;
      hi++;
      @(negedge clk);
    end
    while (!link.slav_sig_out && lo < GAP) begin lo++; @(negedge clk); end
    $display("tx frame %s word=0x%h len=%0d", tag, w, hi);
    chk({tag, "_len"}, hi, FRAME);
    chk({tag, "_word"}, w, exp_w);
    chk({tag, "_gap"}, lo, GAP);
  endtask

  int v0, e0, r0, kk;
  int rises, falls, r1, f1, r2, f2, busy_gaps;
  logic ps;
  logic [W-1:0] w6, rw;

  initial begin
    link.mas_bs_in = 1'b0; link.mas_sig_in = 1'b0; link.board = '0; link.send_req = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_attack_data", link.attack_data, 0);
    chk("rst_attack_valid", link.attack_valid, 0);
    chk("rst_frame_err", link.frame_err, 0);
    chk("rst_slav_bs", link.slav_bs_out, 0);
    chk("rst_slav_sig", link.slav_sig_out, 0);
    chk("rst_tx_busy", link.tx_busy, 0);
    rst_n = 1'b1;
    step();

    // Attack 0xA5C3: one valid pulse at the formula latency, no error.
    link.board = 16'h1234;
    v0 = valid_cnt; e0 = err_cnt;
    send_mas(16'hA5C3, W, 1'b0, 1'b0, 1800);
    chk("a5c3_valid_count", valid_cnt - v0, 1);
    chk_range("a5c3_latency", last_valid_n - last_n0, LAT - 1, LAT + 1);
    chk("a5c3_data", link.attack_data, 16'hA5C3);
    chk("a5c3_no_err", err_cnt - e0, 0);

    // Auto-reply of board 0x1234 after attack 0x0001.
    fork
      send_mas(16'h0001, W, 1'b0, 1'b0, 300);
      tx_observe(16'h1234, "auto_reply");
    join
    step();
    chk("attack_0001", link.attack_data, 16'h0001);

    // Truncated frame after 7 bits, then a full 0xFFFF.
    v0 = valid_cnt; e0 = err_cnt;
    send_mas(16'h5A5A, 7, 1'b0, 1'b0, 20);
    chk("trunc_err_count", err_cnt - e0, 1);
    chk("trunc_no_valid", valid_cnt - v0, 0);
    chk("trunc_data_kept", link.attack_data, 16'h0001);
    send_mas(16'hFFFF, W, 1'b0, 1'b0, 1800);
    chk("ffff_data", link.attack_data, 16'hFFFF);
    chk("ffff_valid_count", valid_cnt - v0, 1);

    // Three extra requests during a frame merge into one follow-on frame.
    chk("pre_merge_idle", link.tx_busy, 0);
    rises = 0; falls = 0; r1 = -1; f1 = -1; r2 = -1; f2 = -1; busy_gaps = 0; ps = 1'b0;
    for (int i = 0; i < 4500; i++) begin
      link.send_req = (i == 0 || i == 100 || i == 500 || i == 900);
      @(negedge clk);
      if (link.slav_sig_out && !ps) begin rises++; if (rises == 1) r1 = i; else if (rises == 2) r2 = i; end
      if (!link.slav_sig_out && ps) begin falls++; if (falls == 1) f1 = i; else if (falls == 2) f2 = i; end
      ps = link.slav_sig_out;
      if (rises > 0 && falls < 2 && !link.tx_busy) busy_gaps++;
      step();
    end
    link.send_req = 1'b0;
    $display("tx merge frames=%0d first=%0d..%0d second=%0d..%0d", rises, r1, f1, r2, f2);
    chk("merge_frames", rises, 2);
    chk("merge_len1", f1 - r1, FRAME);
    chk("merge_len2", f2 - r2, FRAME);
    chk_range("merge_gap", r2 - f1, GAP, GAP + 2);
    chk("merge_busy_gaps", busy_gaps, 0);

    // send_req coinciding with attack_valid yields a single frame.
    r0 = tx_rise_cnt;
    send_mas(16'h0F0F, W, 1'b0, 1'b1, 3500);
    chk("coincide_frames", tx_rise_cnt - r0, 1);

    // Reset mid-TX (bit 5) and mid-RX (bit 9).
    w6 = 16'hBEEF;
    link.mas_sig_in = 1'b1;
    for (int c = 0; c < 952; c++) begin
      link.mas_bs_in = w6[c / CPB];
      link.send_req  = (c == 400);
      step();
    end
    chk("pre_reset_tx_active", link.slav_sig_out, 1);
    #1;
    rst_n = 1'b0;
    link.mas_sig_in = 1'b0; link.mas_bs_in = 1'b0; link.send_req = 1'b0;
    #1;
    chk("mid_rst_attack_data", link.attack_data, 0);
    chk("mid_rst_attack_valid", link.attack_valid, 0);
    chk("mid_rst_frame_err", link.frame_err, 0);
    chk("mid_rst_slav_bs", link.slav_bs_out, 0);
    chk("mid_rst_slav_sig", link.slav_sig_out, 0);
    chk("mid_rst_tx_busy", link.tx_busy, 0);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    link.board = 16'h8001;
    fork
      send_mas(16'h8001, W, 1'b0, 1'b0, 300);
      tx_observe(16'h8001, "post_reset");
    join
    step();
    chk("post_reset_data", link.attack_data, 16'h8001);

    // Randomized frames, truncations and spontaneous requests.
    for (int k = 0; k < 8; k++) begin
      link.board = 16'($urandom);
      rw = 16'($urandom);
      if ($urandom_range(0, 3) == 0)
        send_mas(rw, $urandom_range(1, W - 1), 1'b1, 1'b0, $urandom_range(10, 200));
      else
        send_mas(rw, W, 1'b1, 1'($urandom_range(0, 1)), $urandom_range(10, 400));
    end

    kk = 0;
    while ((link.tx_busy || rxq.size() > 0 || errq.size() > 0) && kk < 6000) begin
      step(); kk++;
    end
    chk_range("drain_cycles", kk, 0, 5999);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/slave_link_uart.md
Name: slave_link_uart

Overview:
- Slave-side endpoint of the master/slave serial link. It terminates the frames the master sends (attack word on MasSlav_A_Attack/MasSlav_Sig) and originates the frames the master receives (slave board word on SlavMas_B/SlavMas_Sig).
- One block contains both directions: an RX deserializer, a TX serializer with a one-deep request latch, and optional auto-reply of the board word after each accepted attack.
- It sits between the slave game logic and the board-to-board wires.

Parameters:
- WIDTH, 16: bits per frame, both directions.
- CLKS_PER_BIT, 100: clk cycles each bit is held on the wire. Must be ≥ 4 and even.
- GAP_CYCLES, 4: minimum idle cycles (sig low) between consecutive TX frames.
- AUTO_REPLY, 1: 1 = queue a board transmit on every accepted attack; 0 = transmit only on send_req.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- mas_bs_in  in  1  master→slave bitstream.
- mas_sig_in  in  1  master→slave frame signal.
- board  in  WIDTH  slave board word to send.
- send_req  in  1  single-cycle request to transmit board.
- attack_data  out  WIDTH  last accepted attack word.
- attack_valid  out  1  one-cycle pulse when attack_data updates.
- frame_err  out  1  one-cycle pulse on a truncated RX frame.
- slav_bs_out  out  1  slave→master bitstream.
- slav_sig_out  out  1  slave→master frame signal.
- tx_busy  out  1  high while a TX frame or gap is in progress, or a request is pending.

Behaviour:

Wire protocol (both directions):
- Idle: sig=0, bs=0.
- Frame: sig=1 for exactly WIDTH*CLKS_PER_BIT cycles. Bit i (LSB first) is driven during cycles [i*CPB, (i+1)*CPB) after sig rises.
- sig returns to 0 in the cycle after the last bit.

Reset (rst_n=0, asynchronous):
- attack_data=0, attack_valid=0, frame_err=0.
- slav_bs_out=0, slav_sig_out=0, tx_busy=0.
- Synchronizers cleared, both FSMs to IDLE, pending request cleared.
- Reset mid-frame aborts the frame immediately. Outputs go idle, no partial word is stored.

RX:
- mas_bs_in and mas_sig_in each pass through a 2-flop synchronizer. All RX timing below refers to the synchronized signals.
- R_IDLE: a rising edge of sig_s → R_DATA. Bit counter=0, cycle counter=0.
- R_DATA: cycle counter counts 0..CPB-1. Sample bs_s into shift[bit] at cycle CPB/2-1. At CPB-1, increment bit. After bit WIDTH-1 is sampled → R_DONE.
- R_DATA with sig_s=0 before bit WIDTH-1 is sampled: pulse frame_err, discard shift, → R_IDLE.
- R_DONE: load attack_data, pulse attack_valid for 1 cycle, → R_WAIT.
- R_WAIT: hold until sig_s=0, then → R_IDLE. A sig held high past the frame end is ignored; a new frame requires a fresh rising edge.
- Latency: attack_valid asserts 2 + (WIDTH-1)*CPB + CPB/2 + 1 cycles after the raw mas_sig_in rises (±1 cycle of synchronizer phase).

TX request:
- The request source is send_req OR (AUTO_REPLY && attack_valid). A one-deep pending flag is set by the request and cleared when a frame starts.
- Requests arriving while the flag is already set merge into it (no count). Simultaneous send_req and auto request produce one frame.
- board is captured into the shift register at frame start, not at request time.

TX FSM:
- T_IDLE: if pending → T_DATA. Load shift=board, slav_sig_out=1 and slav_bs_out=board[0] in the same registered update, clear pending.
- T_DATA: hold each bit CPB cycles, shift LSB first. After WIDTH bits → T_GAP with sig=0, bs=0.
- T_GAP: count GAP_CYCLES, then → T_IDLE.
- A request arriving during T_DATA/T_GAP stays pending and starts the next frame after the gap.
- Outputs are registered (no glitches). First bit appears 1 cycle after the request is seen in T_IDLE.
- tx_busy = pending | (state≠T_IDLE).

Full duplex: RX and TX run independently and may overlap.

Test Plan:
- Reset, then master frame carrying 0xA5C3 (CPB=100): attack_data=0xA5C3 and a single attack_valid pulse within ±1 cycle of the latency formula; frame_err stays 0.
- AUTO_REPLY=1, board=0x1234, attack 0x0001 received: slav_sig_out high for exactly 1600 cycles, bits decode to 0x1234 LSB first, then ≥4 idle cycles.
- Master sig dropped after 7 bits: frame_err pulses once, attack_valid stays 0, attack_data keeps its previous value; next full frame 0xFFFF is accepted.
- send_req pulsed 3× during an active TX frame: exactly one additional frame follows after the 4-cycle gap; tx_busy is continuously high until it ends.
- send_req and attack_valid in the same cycle (AUTO_REPLY=1): exactly one TX frame.
- rst_n asserted mid-TX at bit 5 and mid-RX at bit 9: all outputs 0 immediately; after release, a clean frame 0x8001 is received and transmitted correctly.
